// File: rtl/spi_flash_writer_if.sv
// -----------------------------------------------------------------------------
// spi_flash_writer_if
//   Request/response bundle between the sensor arbitration block (master) and
//   the SPI-flash write engine (slave).
//
//   flash_write_start  master -> slave  request strobe, taken only while ready=1
//   flash_write_data   master -> slave  word to program (DATA_WIDTH bits)
//   flash_write_addr   master -> slave  word address (ADDR_WIDTH bits)
//   flash_write_ready  slave -> master  engine idle, able to accept a request
//   write_error        slave -> master  one-cycle pulse on status-poll timeout
//   last_status        slave -> master  most recent RDSR status byte
// -----------------------------------------------------------------------------
interface spi_flash_writer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 24
);
    logic                  flash_write_start;
    logic [DATA_WIDTH-1:0] flash_write_data;
    logic [ADDR_WIDTH-1:0] flash_write_addr;
    logic                  flash_write_ready;
    logic                  write_error;
    logic [7:0]            last_status;

    modport master (
        output flash_write_start,
        output flash_write_data,
        output flash_write_addr,
        input  flash_write_ready,
        input  write_error,
        input  last_status
    );

    modport slave (
        input  flash_write_start,
        input  flash_write_data,
        input  flash_write_addr,
        output flash_write_ready,
        output write_error,
        output last_status
    );
endinterface

// File: rtl/spi_flash_writer.sv
// -----------------------------------------------------------------------------
// spi_flash_writer
//   SPI-flash write engine. Each accepted request issues WREN, then PAGE
//   PROGRAM with a 24-bit byte address and the data word (MSB first), then
//   polls RDSR until the WIP bit clears. SPI mode 0, single chip select.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset; aborts any transfer at once
//   bus        spi_flash_writer_if.slave: start/data/addr in,
//              ready/write_error/last_status out
//   spi_cs_n   flash chip select, active low
//   spi_sclk   SPI clock, idles low
//   spi_mosi   serial data to flash, 0 whenever cs_n is high
//   spi_miso   serial data from flash, sampled on the clk edge where sclk rises
//
// Build option
//   FLASH_POLL_TIMEOUT_EN  when defined, give up after POLL_MAX busy polls,
//                          return to idle and pulse write_error for one cycle.
//                          When undefined, polling repeats indefinitely and
//                          write_error is tied to 0.
//
// state | meaning
// ------+-------------------------------------------------------------------
// IDLE  | ready=1, cs_n high, waiting for flash_write_start
// WREN  | 8-bit write-enable command 0x06
// GAP1  | cs_n high for CS_HIGH_CYCLES before the program command
// PROG  | 0x02, 24-bit byte address, data word high byte first
// GAP2  | cs_n high for CS_HIGH_CYCLES before a status poll
// POLL  | 0x05 plus 8 dummy bits; miso shifted into the status byte
// CHECK | no cycle of its own: decided on the edge that ends POLL, so ready
//       | rises (or the next GAP2 starts) on the same edge cs_n goes high
// -----------------------------------------------------------------------------
module spi_flash_writer #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 24,
    parameter int CLK_DIV        = 2,
    parameter int CS_HIGH_CYCLES = 4,
    parameter int POLL_MAX       = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_flash_writer_if.slave bus,
    output logic              spi_cs_n,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    if ((DATA_WIDTH < 8) || (DATA_WIDTH % 8 != 0)) begin : g_bad_data_width
        $error("spi_flash_writer: DATA_WIDTH must be a nonzero multiple of 8");
    end
    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("spi_flash_writer: CLK_DIV must be at least 1");
    end
    if (CS_HIGH_CYCLES < 1) begin : g_bad_cs_high
        $error("spi_flash_writer: CS_HIGH_CYCLES must be at least 1");
    end
    if (POLL_MAX < 1) begin : g_bad_poll_max
        $error("spi_flash_writer: POLL_MAX must be at least 1");
    end

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WREN = 3'd1;
    localparam logic [2:0] ST_GAP1 = 3'd2;
    localparam logic [2:0] ST_PROG = 3'd3;
    localparam logic [2:0] ST_GAP2 = 3'd4;
    localparam logic [2:0] ST_POLL = 3'd5;

    // Longest frame is PAGE PROGRAM; every frame is left-aligned in tx_sr.
    localparam int FRAME_BITS = 8 + 24 + DATA_WIDTH;
    localparam int BIT_W      = $clog2(FRAME_BITS + 1);
    localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV + 1) : 1;
    localparam int GAP_W      = (CS_HIGH_CYCLES > 1) ? $clog2(CS_HIGH_CYCLES + 1) : 1;

    localparam logic [BIT_W-1:0] WREN_LAST = BIT_W'(7);
    localparam logic [BIT_W-1:0] PROG_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] POLL_LAST_BIT = BIT_W'(15);
    localparam logic [BIT_W-1:0] RX_FIRST  = BIT_W'(8);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(CS_HIGH_CYCLES - 1);

    logic [2:0]            state;
    logic [BIT_W-1:0]      bit_cnt;
    logic [BIT_W-1:0]      bit_last;
    logic [DIV_W-1:0]      div_cnt;
    logic [GAP_W-1:0]      gap_cnt;
    logic [FRAME_BITS-1:0] tx_sr;
    logic [FRAME_BITS-1:0] wren_frame;
    logic [FRAME_BITS-1:0] prog_frame;
    logic [FRAME_BITS-1:0] poll_frame;
    logic [FRAME_BITS-1:0] gap_frame;
    logic [DATA_WIDTH-1:0] data_q;
    logic [23:0]           byte_addr_q;
    logic [23:0]           byte_addr_in;
    logic [ADDR_WIDTH:0]   addr_x;
    logic [7:0]            rx_sr;
    logic [7:0]            last_status_q;
    logic                  ready_q;

    // Word address to byte address; the size cast truncates wide addresses
    // and zero-extends narrow ones to the flash's 24-bit address field.
    assign addr_x       = {bus.flash_write_addr, 1'b0};
    assign byte_addr_in = 24'(addr_x);

    assign wren_frame = {8'h06, {(FRAME_BITS - 8){1'b0}}};
    assign prog_frame = {8'h02, byte_addr_q, data_q};
    assign poll_frame = {8'h05, {(FRAME_BITS - 8){1'b0}}};
    assign gap_frame  = (state == ST_GAP1) ? prog_frame : poll_frame;

    always_comb begin
        bit_last = POLL_LAST_BIT;
        case (state)
            ST_WREN: bit_last = WREN_LAST;
            ST_PROG: bit_last = PROG_LAST;
            default: bit_last = POLL_LAST_BIT;
        endcase
    end

    assign bus.flash_write_ready = ready_q;
    assign bus.last_status       = last_status_q;

`ifdef FLASH_POLL_TIMEOUT_EN
    localparam int POLL_W = (POLL_MAX > 1) ? $clog2(POLL_MAX + 1) : 1;
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_MAX - 1);

    logic [POLL_W-1:0] poll_cnt;
    logic              write_error_q;

    assign bus.write_error = write_error_q;
`else
    assign bus.write_error = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            bit_cnt       <= '0;
            div_cnt       <= '0;
            gap_cnt       <= '0;
            tx_sr         <= '0;
            data_q        <= '0;
            byte_addr_q   <= '0;
            rx_sr         <= '0;
            last_status_q <= '0;
            ready_q       <= 1'b1;
            spi_cs_n      <= 1'b1;
            spi_sclk      <= 1'b0;
            spi_mosi      <= 1'b0;
`ifdef FLASH_POLL_TIMEOUT_EN
            poll_cnt      <= '0;
            write_error_q <= 1'b0;
`endif
        end else begin
`ifdef FLASH_POLL_TIMEOUT_EN
            write_error_q <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (bus.flash_write_start) begin
                        data_q      <= bus.flash_write_data;
                        byte_addr_q <= byte_addr_in;
                        ready_q     <= 1'b0;
                        state       <= ST_WREN;
                        // cs_n falls with the first command bit already driven
                        spi_cs_n    <= 1'b0;
                        spi_mosi    <= wren_frame[FRAME_BITS-1];
                        tx_sr       <= wren_frame << 1;
                        bit_cnt     <= '0;
                        div_cnt     <= '0;
                        gap_cnt     <= '0;
`ifdef FLASH_POLL_TIMEOUT_EN
                        poll_cnt    <= '0;
`endif
                    end
                end

                ST_GAP1, ST_GAP2: begin
                    if (gap_cnt == GAP_LAST) begin
                        state    <= (state == ST_GAP1) ? ST_PROG : ST_POLL;
                        spi_cs_n <= 1'b0;
                        spi_mosi <= gap_frame[FRAME_BITS-1];
                        tx_sr    <= gap_frame << 1;
                        bit_cnt  <= '0;
                        div_cnt  <= '0;
                        gap_cnt  <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                ST_WREN, ST_PROG, ST_POLL: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end else if (!spi_sclk) begin
                        // Rising sclk edge: the flash has had a full low
                        // phase to settle miso, so sample it now.
                        div_cnt  <= '0;
                        spi_sclk <= 1'b1;
                        if ((state == ST_POLL) && (bit_cnt >= RX_FIRST)) begin
                            rx_sr <= {rx_sr[6:0], spi_miso};
                        end
                    end else begin
                        div_cnt  <= '0;
                        spi_sclk <= 1'b0;
                        if (bit_cnt != bit_last) begin
                            bit_cnt  <= bit_cnt + BIT_W'(1);
                            spi_mosi <= tx_sr[FRAME_BITS-1];
                            tx_sr    <= tx_sr << 1;
                        end else begin
                            spi_cs_n <= 1'b1;
                            spi_mosi <= 1'b0;
                            bit_cnt  <= '0;
                            gap_cnt  <= '0;
                            case (state)
                                ST_WREN: state <= ST_GAP1;
                                ST_PROG: state <= ST_GAP2;
                                default: begin
                                    last_status_q <= rx_sr;
                                    if (rx_sr[0]) begin
`ifdef FLASH_POLL_TIMEOUT_EN
                                        if (poll_cnt == POLL_LAST) begin
                                            state         <= ST_IDLE;
                                            ready_q       <= 1'b1;
                                            write_error_q <= 1'b1;
                                        end else begin
                                            poll_cnt <= poll_cnt + POLL_W'(1);
                                            state    <= ST_GAP2;
                                        end
`else
                                        state <= ST_GAP2;
`endif
                                    end else begin
                                        state   <= ST_IDLE;
                                        ready_q <= 1'b1;
                                    end
                                end
                            endcase
                        end
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    ready_q  <= 1'b1;
                    spi_cs_n <= 1'b1;
                    spi_sclk <= 1'b0;
                    spi_mosi <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_writer.sv
`timescale 1ns/1ps
module tb_spi_flash_writer;
    localparam int DW       = 16;
    localparam int AW       = 24;
    localparam int CLK_DIV  = 2;
    localparam int CS_HIGH  = 4;
    localparam int POLL_MAX = 4;

    typedef struct {
        int          len;
        logic [63:0] bits;
    } txn_t;

    typedef struct {
        int         lat;
        logic [7:0] st;
        logic       err;
    } done_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic spi_cs_n, spi_sclk, spi_mosi;
    logic spi_miso = 1'b0;

    spi_flash_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    spi_flash_writer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLK_DIV(CLK_DIV),
        .CS_HIGH_CYCLES(CS_HIGH), .POLL_MAX(POLL_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    txn_t       exp_txn[$];
    done_t      exp_done[$];
    logic [7:0] stat_list[$];

    function automatic logic [7:0] status_for(input int idx);
        if (stat_list.size() == 0) return 8'h00;
        if (idx < stat_list.size()) return stat_list[idx];
        return stat_list[stat_list.size() - 1];
    endfunction

    task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [AW:0] ax;
        txn_t        t;
        done_t       r;
        int          lat;
        logic [7:0]  s;
        ax = {a, 1'b0};
        t.len = 8;  t.bits = 64'h06;
        exp_txn.push_back(t);
        lat = t.len * 2 * CLK_DIV;
        t.len = 32 + DW; t.bits = 64'({8'h02, ax[23:0], d});
        exp_txn.push_back(t);
        lat += CS_HIGH + t.len * 2 * CLK_DIV;
        r.err = 1'b0;
        s = 8'h00;
        for (int i = 0; i < 1000; i++) begin
            s = status_for(i);
            t.len = 16; t.bits = 64'h0500;
            exp_txn.push_back(t);
            lat += CS_HIGH + t.len * 2 * CLK_DIV;
            if (!s[0]) break;
`ifdef FLASH_POLL_TIMEOUT_EN
            if (i + 1 == POLL_MAX) begin
                r.err = 1'b1;
                break;
            end
`endif
        end
        r.lat = lat;
        r.st  = s;
        exp_done.push_back(r);
    endtask

    // ---------------- monitor / flash model ----------------
    int          cyc = 0, done_cnt = 0, first_fall_cyc = 0, gap_cyc = 0;
    int          txn_idx = 0, cap_len = 0, cap_cyc = 0, poll_idx = 0, sclk_rises = 0;
    logic [63:0] cap_bits = '0;
    logic [7:0]  cap_cmd = '0, cur_status = '0;
    logic        in_txn = 1'b0, mosi_bad = 1'b0, err_check_next = 1'b0;
    logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0, prev_ready = 1'b1;
    txn_t        mon_t;
    done_t       mon_d;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            in_txn = 1'b0; err_check_next = 1'b0; spi_miso = 1'b0;
            prev_cs = 1'b1; prev_sclk = 1'b0; prev_mosi = 1'b0; prev_ready = 1'b1;
            txn_idx = 0; cap_len = 0; cap_cmd = 8'h00;
        end else begin
            if (err_check_next) begin
                chk("write_error_single_cycle", 64'(bus.write_error), 64'd0);
                err_check_next = 1'b0;
            end
            if (spi_sclk && !prev_sclk) sclk_rises++;
            if (!spi_cs_n) begin
                if (prev_cs) begin
                    in_txn = 1'b1; cap_len = 0; cap_bits = '0; cap_cyc = 0;
                    cap_cmd = 8'h00; mosi_bad = 1'b0;
                    if (prev_ready) begin
                        first_fall_cyc = cyc; txn_idx = 0; poll_idx = 0;
                    end else begin
                        chk("cs_gap_cycles", 64'(gap_cyc), 64'(CS_HIGH));
                    end
                end
                cap_cyc++;
                if (spi_sclk && (spi_mosi !== prev_mosi)) mosi_bad = 1'b1;
                if (spi_sclk && !prev_sclk) begin
                    cap_bits = {cap_bits[62:0], spi_mosi};
                    cap_len++;
                    if (cap_len == 8) begin
                        cap_cmd = cap_bits[7:0];
                        if (cap_cmd == 8'h05) cur_status = status_for(poll_idx);
                    end
                end
                if (cap_cmd == 8'h05 && cap_len >= 8 && cap_len < 16)
                    spi_miso = cur_status[3'(15 - cap_len)];
                else
                    spi_miso = 1'b0;
            end else begin
                if (!prev_cs && in_txn) begin
                    in_txn = 1'b0;
                    spi_miso = 1'b0;
                    chk("cs_high_lines_idle", 64'({spi_sclk, spi_mosi}), 64'd0);
                    chk("mosi_stable_while_sclk_high", 64'(mosi_bad), 64'd0);
                    if (exp_txn.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL unexpected_txn: got %0d bits 0x%0h, expected no transaction", cap_len, cap_bits);
                    end else begin
                        mon_t = exp_txn.pop_front();
                        chk("txn_len", 64'(cap_len), 64'(mon_t.len));
                        chk("txn_bits", cap_bits, mon_t.bits);
                        chk("cs_low_cycles", 64'(cap_cyc), 64'(mon_t.len * 2 * CLK_DIV));
                    end
                    if (cap_cmd == 8'h05) poll_idx++;
                    txn_idx++;
                    gap_cyc = 0;
                end
                gap_cyc++;
            end
            if (bus.flash_write_ready && !prev_ready) begin
                done_cnt++;
                if (exp_done.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_completion: got ready rise, expected none");
                end else begin
                    mon_d = exp_done.pop_front();
                    chk("ready_latency", 64'(cyc - first_fall_cyc), 64'(mon_d.lat));
                    chk("last_status", 64'(bus.last_status), 64'(mon_d.st));
                    chk("write_error", 64'(bus.write_error), 64'(mon_d.err));
                end
                err_check_next = 1'b1;
            end
            prev_cs = spi_cs_n; prev_sclk = spi_sclk; prev_mosi = spi_mosi;
            prev_ready = bus.flash_write_ready;
        end
    end

    // ---------------- stimulus ----------------
    task automatic start_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int w;
        w = 0;
        while (!bus.flash_write_ready && w < 5000) begin
            @(negedge clk); w++;
        end
        chk("ready_before_start", 64'(bus.flash_write_ready), 64'd1);
        model_write(a, d);
        @(negedge clk);
        bus.flash_write_start = 1'b1;
        bus.flash_write_addr  = a;
        bus.flash_write_data  = d;
        @(negedge clk);
        bus.flash_write_start = 1'b0;
        bus.flash_write_addr  = ~a;
        bus.flash_write_data  = ~d;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 20000 && done_cnt < target; i++) @(negedge clk);
        chk("completion_within_budget", 64'(done_cnt >= target), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_prog_bit(input int bitn, output logic hit);
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk);
            if (in_txn && txn_idx == 1 && cap_len == bitn) hit = 1'b1;
        end
    endtask

    initial begin
        int          target, s0, nbusy;
        logic        hit;
        logic [AW-1:0] a;
        logic [DW-1:0] d;

        bus.flash_write_start = 1'b0;
        bus.flash_write_addr  = '0;
        bus.flash_write_data  = '0;
        target = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", 64'(bus.flash_write_ready), 64'd1);
        chk("reset_cs_n", 64'(spi_cs_n), 64'd1);
        chk("reset_sclk", 64'(spi_sclk), 64'd0);
        chk("reset_mosi", 64'(spi_mosi), 64'd0);
        chk("reset_last_status", 64'(bus.last_status), 64'd0);
        chk("reset_write_error", 64'(bus.write_error), 64'd0);
        s0 = sclk_rises;
        repeat (100) @(negedge clk);
        chk("idle_sclk_rises", 64'(sclk_rises - s0), 64'd0);
        chk("idle_cs_n", 64'(spi_cs_n), 64'd1);

        // directed write, status ready at once
        stat_list = '{8'h00};
        start_write(24'h000005, 16'hA55A);
        target++; wait_done(target);

        // two busy polls then ready
        stat_list = '{8'h03, 8'h03, 8'h00};
        start_write(24'h123456, 16'h0F1E);
        target++; wait_done(target);
        chk("three_polls_seen", 64'(poll_idx), 64'd3);

        // random writes with random busy sequences
        for (int k = 0; k < 6; k++) begin
            stat_list.delete();
            nbusy = $urandom_range(0, 2);
            for (int j = 0; j < nbusy; j++) stat_list.push_back(8'($urandom()) | 8'h01);
            stat_list.push_back(8'($urandom()) & 8'hFE);
            a = AW'($urandom());
            d = DW'($urandom());
            start_write(a, d);
            target++; wait_done(target);
        end

        // start pulse mid-PROG must be ignored
        stat_list = '{8'h00};
        a = AW'($urandom()); d = DW'($urandom());
        start_write(a, d);
        wait_prog_bit(10, hit);
        chk("reached_prog_bit10", 64'(hit), 64'd1);
        bus.flash_write_start = 1'b1;
        bus.flash_write_addr  = a ^ AW'(24'h5A5A5A);
        bus.flash_write_data  = ~d;
        @(negedge clk);
        bus.flash_write_start = 1'b0;
        target++; wait_done(target);
        repeat (200) @(negedge clk);
        chk("no_extra_txn_after_ignored_start", 64'(exp_txn.size()), 64'd0);

        // reset during PROG bit 20, then a clean write
        stat_list = '{8'h00};
        start_write(AW'($urandom()), DW'($urandom()));
        wait_prog_bit(20, hit);
        chk("reached_prog_bit20", 64'(hit), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_cs_n", 64'(spi_cs_n), 64'd1);
        chk("abort_sclk", 64'(spi_sclk), 64'd0);
        chk("abort_ready", 64'(bus.flash_write_ready), 64'd1);
        exp_txn.delete();
        exp_done.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        stat_list = '{8'h01, 8'h00};
        start_write(AW'($urandom()), DW'($urandom()));
        target++; wait_done(target);

        // stuck busy: times out after POLL_MAX polls only with the option
        stat_list = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00};
        start_write(AW'($urandom()), DW'($urandom()));
        target++; wait_done(target);
`ifdef FLASH_POLL_TIMEOUT_EN
        chk("timeout_poll_count", 64'(poll_idx), 64'(POLL_MAX));
`else
        chk("no_timeout_poll_count", 64'(poll_idx), 64'd7);
`endif

        repeat (20) @(negedge clk);
        chk("leftover_txns", 64'(exp_txn.size()), 64'd0);
        chk("leftover_completions", 64'(exp_done.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no end of test, expected completion within 90000 cycles");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
